// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the RISC-V multicycle core: sequences the shared ALU,
// memory port, IR, PC and register file one instruction step per state.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         i_opcode,
  input  logic [2:0]         i_funct3,
  input  logic               i_zero,
  input  logic               i_mem_ready,
  output logic               o_pc_write,
  output logic               o_ir_write,
  output logic               o_adr_src,
  output logic               o_mem_req,
  output logic               o_mem_write,
  output logic               o_reg_write,
  output logic               o_rf_pc_sel,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [2:0]         o_alu_op,
  output logic [1:0]         o_result_src,
  output logic               o_illegal,
  output logic [STATE_W-1:0] o_state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    AUIPC    = 4'd11
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_DECODE = 3'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = FETCH;
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_rf_pc_sel  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRC_B_REG;
    o_alu_op     = ALU_ADD;
    o_result_src = RES_ALUOUT;
    o_illegal    = 1'b0;

    case (state)
      FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = SRC_B_FOUR;
        o_result_src = RES_ALU;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        // ALU forms the branch target into ALUOut while the opcode is decoded
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_DECODE;
        case (i_opcode)
          OPC_LOAD, OPC_STORE: state_next = MEMADR;
          OPC_RTYPE:           state_next = EXEC_R;
          OPC_ITYPE:           state_next = EXEC_I;
          OPC_BRANCH:          state_next = BRANCH;
          OPC_JAL:             state_next = JAL;
          OPC_AUIPC:           state_next = AUIPC;
          default: begin
            o_illegal  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRC_B_IMM;
        state_next  = (i_opcode == OPC_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        o_adr_src  = 1'b1;
        o_mem_req  = 1'b1;
        state_next = i_mem_ready ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        state_next  = i_mem_ready ? FETCH : MEMWRITE;
      end
      MEMWB: begin
        o_result_src = RES_MEM;
        o_reg_write  = 1'b1;
      end
      EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRC_B_REG;
        o_alu_op    = ALU_DECODE;
        state_next  = ALUWB;
      end
      EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_DECODE;
        state_next  = ALUWB;
      end
      AUIPC: begin
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_DECODE;
        state_next  = ALUWB;
      end
      ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_write  = 1'b1;
      end
      BRANCH: begin
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRC_B_REG;
        o_alu_op     = ALU_SUB;
        o_result_src = RES_ALUOUT;
        o_pc_write   = ((i_funct3 == F3_BEQ) &&  i_zero) ||
                       ((i_funct3 == F3_BNE) && !i_zero);
      end
      JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        o_alu_src_b  = SRC_B_IMM;
        o_alu_op     = ALU_DECODE;
        o_result_src = RES_ALU;
        o_pc_write   = 1'b1;
        o_reg_write  = 1'b1;
        o_rf_pc_sel  = 1'b1;
      end
      default: state_next = FETCH;
    endcase

    if (rst) begin
      o_pc_write   = 1'b0;
      o_ir_write   = 1'b0;
      o_adr_src    = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_write  = 1'b0;
      o_reg_write  = 1'b0;
      o_rf_pc_sel  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = '0;
      o_alu_op     = '0;
      o_result_src = '0;
      o_illegal    = 1'b0;
    end
  end

  always_comb begin
    o_state = rst ? '0 : STATE_W'(state);
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver pushes the per-cycle
// expected output word derived from instruction-level rules, a monitor pops and compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic       i_zero = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic       o_pc_write, o_ir_write, o_adr_src, o_mem_req, o_mem_write;
  logic       o_reg_write, o_rf_pc_sel, o_alu_src_a, o_illegal;
  logic [1:0] o_alu_src_b, o_result_src;
  logic [2:0] o_alu_op;
  logic [3:0] o_state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_adr_src(o_adr_src),
    .o_mem_req(o_mem_req), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_rf_pc_sel(o_rf_pc_sel), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_result_src(o_result_src), .o_illegal(o_illegal),
    .o_state(o_state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, req, mw, rw, rfpc, ill, a;
    logic [1:0] b;
    logic [2:0] op;
    logic [1:0] rs;
  } row_t;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BR = 7'b1100011, JALO = 7'b1101111;
  localparam logic [6:0] AUIPCO = 7'b0010111, LUI = 7'b0110111;

  row_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Expected outputs of one step of an instruction (state number as exported)
  function automatic row_t row(input int st, input logic pcw, input logic irw, input logic ill);
    row_t r = '0;
    r.st = st[3:0]; r.pcw = pcw; r.irw = irw; r.ill = ill;
    case (st)
      0:  begin r.req = 1; r.b = 2; r.rs = 2; end
      1:  begin r.b = 1; r.op = 2; end
      2:  begin r.a = 1; r.b = 1; end
      3:  begin r.adr = 1; r.req = 1; end
      4:  begin r.rs = 1; r.rw = 1; end
      5:  begin r.adr = 1; r.req = 1; r.mw = 1; end
      6:  begin r.a = 1; r.op = 2; end
      7:  begin r.a = 1; r.b = 1; r.op = 2; end
      8:  begin r.rw = 1; end
      9:  begin r.a = 1; r.op = 1; end
      10: begin r.b = 1; r.op = 2; r.rs = 2; r.pcw = 1; r.rw = 1; r.rfpc = 1; end
      11: begin r.b = 1; r.op = 2; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    return opc inside {LOAD, STORE, RTYPE, ITYPE, BR, JALO, AUIPCO};
  endfunction

  task automatic cyc(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                     input logic z, input logic rdy, input row_t e);
    rst = r; i_opcode = opc; i_funct3 = f3; i_zero = z; i_mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Fetch + decode, then the class-specific steps; mem_ready in non-memory
  // states and zero outside BRANCH are random because they must be ignored.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int fw, input int mw, input logic rst_mid);
    for (int i = 0; i < fw; i++)
      cyc(0, 7'($urandom), 3'($urandom), 1'($urandom), 0, row(0, 0, 0, 0));
    cyc(0, 7'($urandom), 3'($urandom), 1'($urandom), 1, row(0, 1, 1, 0));
    cyc(0, opc, f3, 1'($urandom), 1'($urandom), row(1, 0, 0, !is_legal(opc)));
    case (opc)
      LOAD, STORE: begin
        int ms;
        ms = (opc == LOAD) ? 3 : 5;
        cyc(0, opc, f3, 1'($urandom), 1'($urandom), row(2, 0, 0, 0));
        for (int i = 0; i < mw; i++)
          cyc(0, opc, f3, 1'($urandom), 0, row(ms, 0, 0, 0));
        if (rst_mid) begin
          cyc(1, opc, f3, 1'($urandom), 1'($urandom), '0);
          cyc(1, opc, f3, 1'($urandom), 1'($urandom), '0);
        end else begin
          cyc(0, opc, f3, 1'($urandom), 1, row(ms, 0, 0, 0));
          if (opc == LOAD) cyc(0, opc, f3, 1'($urandom), 1'($urandom), row(4, 0, 0, 0));
        end
      end
      RTYPE, ITYPE, AUIPCO: begin
        cyc(0, opc, f3, 1'($urandom), 1'($urandom),
            row((opc == RTYPE) ? 6 : (opc == ITYPE) ? 7 : 11, 0, 0, 0));
        cyc(0, opc, f3, 1'($urandom), 1'($urandom), row(8, 0, 0, 0));
      end
      BR: cyc(0, opc, f3, z, 1'($urandom),
              row(9, (f3 == 3'd0 && z) || (f3 == 3'd1 && !z), 0, 0));
      JALO: cyc(0, opc, f3, 1'($urandom), 1'($urandom), row(10, 1, 0, 0));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    row_t act, e;
    act = '{st: o_state, pcw: o_pc_write, irw: o_ir_write, adr: o_adr_src,
            req: o_mem_req, mw: o_mem_write, rw: o_reg_write, rfpc: o_rf_pc_sel,
            ill: o_illegal, a: o_alu_src_a, b: o_alu_src_b, op: o_alu_op,
            rs: o_result_src};
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL step t=%0t state=%0d actual=%h required=%h", $time, e.st, act, e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] opc_tab [9];
    opc_tab = '{LOAD, STORE, RTYPE, ITYPE, BR, JALO, AUIPCO, LUI, 7'b1100111};
    @(posedge clk); #1;
    cyc(1, '0, '0, 0, 1, '0);
    cyc(1, '0, '0, 0, 0, '0);

    run_instr(RTYPE, 3'd0, 0, 0, 0, 0);
    run_instr(LOAD,  3'd2, 0, 0, 3, 0);
    run_instr(BR,    3'd0, 1, 0, 0, 0);
    run_instr(BR,    3'd0, 0, 1, 0, 0);
    run_instr(BR,    3'd1, 1, 0, 0, 0);
    run_instr(BR,    3'd1, 0, 0, 0, 0);
    run_instr(BR,    3'd4, 1, 0, 0, 0);
    run_instr(LUI,   3'd0, 0, 0, 0, 0);
    run_instr(JALO,  3'd0, 0, 2, 0, 0);
    run_instr(STORE, 3'd2, 0, 0, 1, 0);
    run_instr(ITYPE, 3'd0, 0, 0, 0, 0);
    run_instr(AUIPCO, 3'd0, 0, 0, 0, 0);
    run_instr(LOAD,  3'd2, 0, 0, 1, 1);
    run_instr(RTYPE, 3'd0, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++)
      run_instr(opc_tab[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 19) == 0));

    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
